// File: rtl/sync_fifo_flags.sv
// Single-clock parametrised FIFO with occupancy count, programmable
// almost-full/almost-empty flags, optional first-word-fall-through read,
// synchronous flush and sticky overflow/underflow error flags.
module sync_fifo_flags #(
   parameter int DEPTH      = 256,
   parameter int DATA_WIDTH = 8,
   parameter int PTR_WIDTH  = $clog2(DEPTH),
   parameter int AF_THRESH  = 240,
   parameter int AE_THRESH  = 16,
   parameter int FWFT       = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  w_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  r_en,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  rd_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [PTR_WIDTH:0]    count,
   input  logic                  err_clr,
   output logic                  overflow,
   output logic                  underflow
);

   // Thresholds and constants sized to the count/pointer width so that all
   // comparisons and increments are width-matched.
   localparam logic [PTR_WIDTH:0] DEPTH_CNT = DEPTH[PTR_WIDTH:0];
   localparam logic [PTR_WIDTH:0] AF_CNT    = AF_THRESH[PTR_WIDTH:0];
   localparam logic [PTR_WIDTH:0] AE_CNT    = AE_THRESH[PTR_WIDTH:0];
   localparam logic [PTR_WIDTH:0] ONE       = {{PTR_WIDTH{1'b0}}, 1'b1};

   // Reject illegal parameter sets at elaboration time.
   if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $fatal(1, "sync_fifo_flags: DEPTH must be a power of two >= 4");
   end
   if (PTR_WIDTH != $clog2(DEPTH)) begin : g_bad_ptr
      $fatal(1, "sync_fifo_flags: PTR_WIDTH must equal clog2(DEPTH)");
   end
   if ((AE_THRESH < 0) || (AE_THRESH >= AF_THRESH) || (AF_THRESH > DEPTH)) begin : g_bad_thresh
      $fatal(1, "sync_fifo_flags: need 0 <= AE_THRESH < AF_THRESH <= DEPTH");
   end

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [PTR_WIDTH:0] wptr_reg, wptr_next;
   logic [PTR_WIDTH:0] rptr_reg, rptr_next;
   logic [PTR_WIDTH:0] count_reg, count_next;
   logic               full_reg, empty_reg, af_reg, ae_reg;
   logic               overflow_reg, underflow_reg;
   logic               wr_acc, rd_acc;
   logic [PTR_WIDTH-1:0] waddr, raddr;

   // A rejected write (FIFO full) stays rejected even when a read is
   // accepted in the same cycle; flush overrides both requests.
   assign wr_acc = w_en && !full_reg && !flush;
   assign rd_acc = r_en && !empty_reg && !flush;
   assign waddr  = wptr_reg[PTR_WIDTH-1:0];
   assign raddr  = rptr_reg[PTR_WIDTH-1:0];

   // Next pointer and occupancy values; flags are derived from these so the
   // registered flags track the post-edge occupancy without lag.
   always_comb begin
      wptr_next  = wptr_reg;
      rptr_next  = rptr_reg;
      count_next = count_reg;
      if (flush) begin
         wptr_next  = '0;
         rptr_next  = '0;
         count_next = '0;
      end else begin
         if (wr_acc) begin
            wptr_next = wptr_reg + ONE;
         end
         if (rd_acc) begin
            rptr_next = rptr_reg + ONE;
         end
         case ({wr_acc, rd_acc})
            2'b10:   count_next = count_reg + ONE;
            2'b01:   count_next = count_reg - ONE;
            default: count_next = count_reg;
         endcase
      end
   end

   // Pointer, occupancy and flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_reg  <= '0;
         rptr_reg  <= '0;
         count_reg <= '0;
         full_reg  <= 1'b0;
         empty_reg <= 1'b1;
         af_reg    <= 1'b0;
         ae_reg    <= 1'b1;
      end else begin
         wptr_reg  <= wptr_next;
         rptr_reg  <= rptr_next;
         count_reg <= count_next;
         full_reg  <= (count_next == DEPTH_CNT);
         empty_reg <= (count_next == '0);
         af_reg    <= (count_next >= AF_CNT);
         ae_reg    <= (count_next <= AE_CNT);
      end
   end

   // Sticky error flags: a set in the same cycle as err_clr wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         if (w_en && full_reg) begin
            overflow_reg <= 1'b1;
         end else if (err_clr) begin
            overflow_reg <= 1'b0;
         end
         if (r_en && empty_reg) begin
            underflow_reg <= 1'b1;
         end else if (err_clr) begin
            underflow_reg <= 1'b0;
         end
      end
   end

   // Storage array; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[waddr] <= data_in;
      end
   end

   if (FWFT != 0) begin : g_fwft
      // Head of the queue is always presented; the slot just written is
      // visible right after the write edge, including the count==1
      // simultaneous read/write case where rptr moves onto it.
      assign data_out = empty_reg ? '0 : mem[raddr];
      assign rd_valid = !empty_reg;
   end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_reg;
      logic                  valid_reg;

      // Registered read: data appears one cycle after an accepted r_en and
      // holds until the next accepted read.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            dout_reg  <= '0;
            valid_reg <= 1'b0;
         end else begin
            valid_reg <= rd_acc;
            if (rd_acc) begin
               dout_reg <= mem[raddr];
            end
         end
      end

      assign data_out = dout_reg;
      assign rd_valid = valid_reg;
   end

   assign full         = full_reg;
   assign empty        = empty_reg;
   assign almost_full  = af_reg;
   assign almost_empty = ae_reg;
   assign count        = count_reg;
   assign overflow     = overflow_reg;
   assign underflow    = underflow_reg;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed self-checking bench for sync_fifo_flags. A standard-read and a
// FWFT instance share all inputs; a queue model supplies expected data.
module tb_sync_fifo_flags;

   logic       clk = 1'b0;
   logic       rst_n, flush, w_en, r_en, err_clr;
   logic [7:0] data_in;

   logic [7:0] data_out, f_data_out;
   logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
   logic       f_rd_valid, f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
   logic [8:0] count, f_count;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] q[$];
   logic [7:0] exp_data;

   always #5 clk = ~clk;

   sync_fifo_flags #(.FWFT(0)) u_dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .w_en(w_en), .data_in(data_in),
      .r_en(r_en), .data_out(data_out), .rd_valid(rd_valid), .full(full),
      .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
      .count(count), .err_clr(err_clr), .overflow(overflow), .underflow(underflow)
   );

   sync_fifo_flags #(.FWFT(1)) u_dut_fwft (
      .clk(clk), .rst_n(rst_n), .flush(flush), .w_en(w_en), .data_in(data_in),
      .r_en(r_en), .data_out(f_data_out), .rd_valid(f_rd_valid), .full(f_full),
      .empty(f_empty), .almost_full(f_almost_full), .almost_empty(f_almost_empty),
      .count(f_count), .err_clr(err_clr), .overflow(f_overflow), .underflow(f_underflow)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [7:0] d);
      w_en = 1'b1; data_in = d;
      tick();
      w_en = 1'b0;
      q.push_back(d);
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; w_en = 1'b0; r_en = 1'b0; err_clr = 1'b0; data_in = 8'h00;

      // 1. Reset then idle
      tick(); tick();
      rst_n = 1'b1;
      tick(); tick();
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_ae",    32'(almost_empty), 32'd1);
      check("rst_full",  32'(full), 32'd0);
      check("rst_af",    32'(almost_full), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_dout",  32'(data_out), 32'd0);
      check("rst_valid", 32'(rd_valid), 32'd0);
      check("rst_ovf",   32'(overflow), 32'd0);
      check("rst_unf",   32'(underflow), 32'd0);
      $display("[TB] reset checks done");

      // 2. Fill to full, overflow, drain in order, underflow
      for (int i = 0; i < 256; i++) begin
         push_word(8'($urandom));
         check("fill_count", 32'(count), 32'(i + 1));
         check("fill_af",    32'(almost_full), 32'((i + 1) >= 240));
         check("fill_ae",    32'(almost_empty), 32'((i + 1) <= 16));
      end
      check("fill_full", 32'(full), 32'd1);
      w_en = 1'b1; data_in = 8'hEE;
      tick();
      w_en = 1'b0;
      check("ovf_count", 32'(count), 32'd256);
      check("ovf_flag",  32'(overflow), 32'd1);
      for (int i = 0; i < 256; i++) begin
         r_en = 1'b1;
         tick();
         exp_data = q.pop_front();
         check("drain_data",  32'(data_out), 32'(exp_data));
         check("drain_valid", 32'(rd_valid), 32'd1);
         check("drain_count", 32'(count), 32'(255 - i));
      end
      r_en = 1'b0;
      tick();
      check("drain_empty", 32'(empty), 32'd1);
      check("pulse_end",   32'(rd_valid), 32'd0);
      check("dout_hold",   32'(data_out), 32'(exp_data));
      r_en = 1'b1;
      tick();
      r_en = 1'b0;
      check("unf_flag",  32'(underflow), 32'd1);
      check("unf_valid", 32'(rd_valid), 32'd0);
      check("unf_count", 32'(count), 32'd0);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("clr_ovf", 32'(overflow), 32'd0);
      check("clr_unf", 32'(underflow), 32'd0);
      $display("[TB] fill/drain done");

      // 3. Wrap three times
      for (int rep = 0; rep < 3; rep++) begin
         for (int i = 0; i < 200; i++) begin
            push_word(8'($urandom));
            check("wrap_notfull", 32'(full), 32'd0);
         end
         for (int i = 0; i < 200; i++) begin
            r_en = 1'b1;
            tick();
            exp_data = q.pop_front();
            check("wrap_data", 32'(data_out), 32'(exp_data));
         end
         r_en = 1'b0;
         check("wrap_count", 32'(count), 32'd0);
         $display("[TB] wrap pass %0d done", rep);
      end

      // 4. Simultaneous read/write at count 100, then at full
      for (int i = 0; i < 100; i++) push_word(8'($urandom));
      for (int i = 0; i < 50; i++) begin
         w_en = 1'b1; r_en = 1'b1; data_in = 8'($urandom);
         tick();
         exp_data = q.pop_front();
         q.push_back(data_in);
         check("rw_data",  32'(data_out), 32'(exp_data));
         check("rw_count", 32'(count), 32'd100);
      end
      w_en = 1'b0; r_en = 1'b0;
      for (int i = 0; i < 156; i++) push_word(8'($urandom));
      check("rw_full", 32'(full), 32'd1);
      w_en = 1'b1; r_en = 1'b1; data_in = 8'h99;
      tick();
      w_en = 1'b0; r_en = 1'b0;
      exp_data = q.pop_front();
      check("rwfull_count", 32'(count), 32'd255);
      check("rwfull_ovf",   32'(overflow), 32'd1);
      check("rwfull_data",  32'(data_out), 32'(exp_data));
      check("rwfull_nfull", 32'(full), 32'd0);
      $display("[TB] simultaneous r/w done");

      // 6. Flush, flush with write, error clear
      flush = 1'b1;
      tick();
      flush = 1'b0;
      q.delete();
      check("flush_count", 32'(count), 32'd0);
      check("flush_empty", 32'(empty), 32'd1);
      for (int i = 0; i < 50; i++) push_word(8'(i + 1));
      check("pre_flush_count", 32'(count), 32'd50);
      flush = 1'b1; w_en = 1'b1; data_in = 8'h77;
      tick();
      flush = 1'b0; w_en = 1'b0;
      q.delete();
      check("flushw_count", 32'(count), 32'd0);
      check("flushw_empty", 32'(empty), 32'd1);
      check("flushw_ae",    32'(almost_empty), 32'd1);
      check("flushw_ovf",   32'(overflow), 32'd1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("clr2_ovf", 32'(overflow), 32'd0);
      check("clr2_unf", 32'(underflow), 32'd0);
      push_word(8'h3C);
      check("postflush_count", 32'(count), 32'd1);
      r_en = 1'b1;
      tick();
      r_en = 1'b0;
      exp_data = q.pop_front();
      check("postflush_data", 32'(data_out), 32'(exp_data));
      check("postflush_empty", 32'(empty), 32'd1);
      $display("[TB] flush done");

      // 5. FWFT behaviour on the second instance
      check("fw_idle_valid", 32'(f_rd_valid), 32'd0);
      w_en = 1'b1; data_in = 8'hA5;
      tick();
      w_en = 1'b0;
      check("fw_data",  32'(f_data_out), 32'hA5);
      check("fw_valid", 32'(f_rd_valid), 32'd1);
      check("fw_nempty", 32'(f_empty), 32'd0);
      r_en = 1'b1;
      tick();
      r_en = 1'b0;
      check("fw_pop_empty", 32'(f_empty), 32'd1);
      check("fw_pop_valid", 32'(f_rd_valid), 32'd0);
      w_en = 1'b1; data_in = 8'h11;
      tick();
      w_en = 1'b1; r_en = 1'b1; data_in = 8'h22;
      tick();
      w_en = 1'b0; r_en = 1'b0;
      check("fw_bypass_data",  32'(f_data_out), 32'h22);
      check("fw_bypass_count", 32'(f_count), 32'd1);
      r_en = 1'b1;
      tick();
      r_en = 1'b0;
      check("fw_final_empty", 32'(f_empty), 32'd1);
      $display("[TB] fwft done");

      // Asynchronous reset in the middle of a write burst
      r_en = 1'b1;
      tick();
      r_en = 1'b0;
      check("pre_rst_unf", 32'(underflow), 32'd1);
      for (int i = 0; i < 5; i++) begin
         w_en = 1'b1; data_in = 8'(8'h40 + i);
         tick();
      end
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_count", 32'(count), 32'd0);
      check("arst_empty", 32'(empty), 32'd1);
      check("arst_ae",    32'(almost_empty), 32'd1);
      check("arst_full",  32'(full), 32'd0);
      check("arst_af",    32'(almost_full), 32'd0);
      check("arst_dout",  32'(data_out), 32'd0);
      check("arst_valid", 32'(rd_valid), 32'd0);
      check("arst_unf",   32'(underflow), 32'd0);
      check("arst_ovf",   32'(overflow), 32'd0);
      check("arst_fdout", 32'(f_data_out), 32'd0);
      check("arst_fvalid", 32'(f_rd_valid), 32'd0);
      w_en = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      check("rel_count", 32'(count), 32'd0);
      w_en = 1'b1; data_in = 8'h5C;
      tick();
      w_en = 1'b0;
      check("rel_fw_data", 32'(f_data_out), 32'h5C);
      r_en = 1'b1;
      tick();
      r_en = 1'b0;
      check("rel_data",  32'(data_out), 32'h5C);
      check("rel_empty", 32'(empty), 32'd1);
      $display("[TB] async reset done");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
Single-clock, parametrised FIFO. It is the successor to the team's 256x8 dual-clock FIFO and is used where producer and consumer share one clock domain. Beyond full/empty it provides:
- occupancy count
- programmable almost-full and almost-empty flags
- selectable standard or first-word-fall-through (FWFT) read mode
- synchronous flush
- sticky overflow and underflow error flags

Parameters:
DEPTH, 256, number of entries; power of two, >= 4
DATA_WIDTH, 8, width of data_in/data_out
PTR_WIDTH, $clog2(DEPTH) = 8, address width; pointers are PTR_WIDTH+1 bits
AF_THRESH, 240, almost_full asserted when count >= AF_THRESH
AE_THRESH, 16, almost_empty asserted when count <= AE_THRESH
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  input  1  single clock, rising-edge
rst_n  input  1  asynchronous, active-low reset
flush  input  1  synchronous clear of contents
w_en  input  1  write request
data_in  input  DATA_WIDTH  write data
r_en  input  1  read/pop request
data_out  output  DATA_WIDTH  read data
rd_valid  output  1  data_out valid (see Behaviour)
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_THRESH
almost_empty  output  1  count <= AE_THRESH
count  output  PTR_WIDTH+1  current occupancy, 0..DEPTH
err_clr  input  1  clears sticky error flags
overflow  output  1  sticky, write attempted while full
underflow  output  1  sticky, read attempted while empty

Behaviour:
- Reset (rst_n=0, asynchronous):
  - wptr = rptr = 0, count = 0
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0
  - data_out = 0, rd_valid = 0, overflow = 0, underflow = 0
  - Memory contents are not reset.
- Reset mid-operation: all stored data is discarded. After release, the first write lands at address 0.
- Pointers: binary, PTR_WIDTH+1 bits; address = low PTR_WIDTH bits; the MSB toggles on wrap.
  - full: MSBs differ and low bits are equal.
  - empty: pointers are equal.
- Write accept = w_en && !full. A write while full is rejected even if a read is accepted in the same cycle. Data is stored at wptr and wptr increments on the same edge.
- Read accept = r_en && !empty. rptr increments on the accepting edge.
- Simultaneous accepted read and write: count unchanged, flags unchanged. When count==1 in FWFT mode, the head updates to the newly written word.
- count, full, empty, almost_full and almost_empty are all registered. They reflect the post-edge occupancy, with no extra cycle lag.
- FWFT=0:
  - data_out <= mem[rptr] on an accepted read, so data appears 1 cycle after r_en.
  - rd_valid is a 1-cycle pulse in that same cycle.
  - data_out holds its value when no read occurs.
- FWFT=1:
  - data_out = mem[rptr] whenever !empty; rd_valid = !empty.
  - A word written at edge N is visible after edge N.
  - r_en pops the current head; the next word is visible after the edge.
- flush=1: wptr, rptr and count clear, and flags return to their reset values on the next edge. flush takes priority over w_en and r_en in the same cycle. flush does not touch overflow/underflow.
- overflow is set on any edge with w_en && full. underflow is set on any edge with r_en && empty. Both hold until err_clr=1 or reset. If set and clear occur in the same cycle, set wins.
- Elaboration checks: DEPTH is a power of two; 0 <= AE_THRESH < AF_THRESH <= DEPTH. A violation triggers $fatal.

Test Plan:
(All scenarios use default parameters: DEPTH=256, DATA_WIDTH=8, AF_THRESH=240, AE_THRESH=16.)
1. Reset, then idle 2 cycles -> empty=1, almost_empty=1, full=0, count=0, data_out=0, rd_valid=0.
2. FWFT=0: write 256 random bytes, then 1 extra write -> count reaches 256, full=1, almost_full rises at count 240, overflow=1, 257th byte dropped. Read 256 -> data matches a queue model in order, each word 1 cycle after r_en, empty=1 at the end. 1 extra read -> underflow=1.
3. Wrap: repeat write 200 / read 200 three times -> addresses wrap past 255, data order preserved, count returns to 0, full never asserted.
4. Simultaneous read and write at count=100 for 50 cycles -> count stays 100, output data continues in FIFO order. At count=256, a simultaneous read+write -> read accepted, write rejected, count=255, overflow=1.
5. FWFT=1: write 0xA5 into an empty FIFO -> data_out=0xA5 and rd_valid=1 the cycle after the write. Pop with r_en -> empty=1, rd_valid=0.
6. Fill 50, assert flush together with w_en=1 -> count=0, empty=1, write ignored, overflow unchanged. Then err_clr=1 -> overflow=0, underflow=0. Assert rst_n=0 mid-burst -> all outputs reach reset values without waiting for a clock edge.
